fir_output_monitor: RTL and testbench
=====================================

# fir_output_monitor

Synthesizable measurement block on the output side of the FIR filter. It consumes the filter's 32-bit signed output stream and skips a configurable settling period covering the filter latency and transient. Over a fixed window of valid samples it measures maximum, minimum, peak-to-peak and zero-crossing count. Results are presented through a valid/ready handshake for on-chip self-test and readback.

## Interface
- `DATA_W`, 32: sample width, signed; matches FIR `output_data`.
- `SETTLE_SAMPLES`, 32: valid samples discarded after start; 0 allowed (skip SETTLE).
- `WINDOW`, 256: valid samples measured per run; must be ≥ 2.
- `ZC_W`, 16: zero-crossing counter width; counter saturates at all-ones.
- `HYST`, 64: hysteresis threshold, non-negative; used only with `MON_HYST_EN`.

- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; honoured only in IDLE, or in REPORT on the handshake cycle.
- `sample_valid` in 1: `sample_data` is valid this cycle.
- `sample_data` in DATA_W: signed FIR output sample.
- `busy` out 1: high in SETTLE, MEASURE and REPORT.
- `res_valid` out 1: result available; high only in REPORT.
- `res_ready` in 1: consumer accepts the result.
- `res_max` out DATA_W: signed maximum over the window.
- `res_min` out DATA_W: signed minimum over the window.
- `res_p2p` out DATA_W+1: unsigned `res_max - res_min`; never overflows.
- `res_zc` out ZC_W: number of sign transitions in the window.
- `res_dropped` out 1: at least one `sample_valid` arrived during REPORT.

## Operation
- States: IDLE → SETTLE → MEASURE → REPORT → IDLE.
- IDLE: `start` goes to SETTLE, or to MEASURE if `SETTLE_SAMPLES` = 0. Samples are ignored.
- SETTLE: count valid samples. When the `SETTLE_SAMPLES`-th is counted, go to MEASURE. That sample is not measured.
- MEASURE, first valid sample: loads max, min and the sign reference. Zero-crossing count = 0.
- MEASURE, each later valid sample: max/min update by signed compare. A sign change increments the zero-crossing count.
  - Sign is the MSB; 0 counts as non-negative.
- MEASURE, `WINDOW`-th valid sample: processed, then REPORT. `res_*` are registered on that edge.
- REPORT: `res_*` stay stable until `res_valid && res_ready`. Any `sample_valid` sets `res_dropped`. Samples are not measured.
- Handshake cycle: `start` also high → SETTLE/MEASURE directly, no IDLE cycle. Otherwise → IDLE.
- `start` in SETTLE or MEASURE: ignored. `start` in REPORT without handshake: ignored.
- Cycles with `sample_valid` low: no count advance, no state change.
- Counter saturation: zero-crossing count holds at 2^ZC_W-1.

## Timing
- Reset values: `busy`=0, `res_valid`=0, all `res_*`=0, state IDLE, all counters 0.
- Reset wins over every other input in the same cycle. Reset mid-run aborts with no result.
- `start` at edge N: `busy`=1 from N+1. The first sample that can be counted is the one presented at N+1.
- Last window sample at edge M: `res_valid`=1 and results valid from M+1.
- Handshake at edge K: `res_valid`=0 from K+1. `busy`=0 from K+1 unless restarted.
- Throughput: one sample per cycle, no stalls. Minimum run = SETTLE_SAMPLES + WINDOW valid cycles + 1 REPORT cycle.

## Configuration
- `MON_HYST_EN` defined: the sign reference flips to positive only when sample > +HYST, and to negative only when sample < −HYST. Each flip counts as one crossing. The first measured sample sets the initial reference by plain MSB sign.
- `MON_HYST_EN` undefined: plain MSB sign-change counting. The `HYST` parameter has no effect.

## Structure
- Package `fir_mon_pkg` holds:
  - State enum `fir_mon_state_t` (IDLE, SETTLE, MEASURE, REPORT).
  - Localparam helpers for counter widths (`$clog2` of SETTLE_SAMPLES+1 and WINDOW+1).
  - Default parameter constants shared with the FIR bench.
- One sub-module, `fir_mon_zc_detector`, takes `DATA_W` and `HYST`:
  - Inputs: sample, valid, `first` (initialise reference).
  - Output: one-cycle `crossing` strobe.
  - Contains the `MON_HYST_EN` logic.
- Top holds the FSM, max/min registers, counters and output registers.

## Test plan
- Basic window: SETTLE_SAMPLES=4, WINDOW=8.
  - Stimulus: four samples of 5000, then 100, −100 alternating ×4.
  - Expect: `res_max`=100, `res_min`=−100, `res_p2p`=200, `res_zc`=7.
- Hysteresis: same setup, window samples 50, −50 alternating.
  - Expect `res_zc`=7 without `MON_HYST_EN`.
  - Expect `res_zc`=0 with `MON_HYST_EN`, HYST=64.
- Gapped valid plus backpressure: `sample_valid` toggling 1/0, `res_ready` low for 10 cycles after `res_valid`.
  - Expect results unchanged while held.
  - Expect `res_dropped`=1 if samples arrived during REPORT.
  - Expect `res_valid` to fall one cycle after `res_ready`.
- Extremes: window contains 2^31−1 and −2^31.
  - Expect `res_p2p` = 2^32−1, no overflow.
- Restart and abort:
  - `start` on the handshake cycle → `busy` stays 1 and the next run begins.
  - `reset` mid-MEASURE → next cycle all outputs 0, IDLE.
  - Later `start` → full clean run.
- Sine sanity: 200 kHz sine sampled at 1 MHz, amplitude 16383, WINDOW=250, fed through FIR and monitor.
  - Expect `res_zc` = 99 ±1.
  - Expect `res_p2p` within the 2× amplitude the filter gain predicts.

Source files
------------

// File: rtl/fir_mon_pkg.sv
// Shared types, width helpers and default parameters for the FIR output monitor.
// No logic; imported by the monitor RTL and the FIR bench.
package fir_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } fir_mon_state_t;

    localparam int FIR_MON_DATA_W         = 32;
    localparam int FIR_MON_SETTLE_SAMPLES = 32;
    localparam int FIR_MON_WINDOW         = 256;
    localparam int FIR_MON_ZC_W           = 16;
    localparam int FIR_MON_HYST           = 64;

    // Counter width able to hold 0..n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fir_mon_zc_detector.sv
// Sign-change detector: combinational crossing strobe on the same cycle as the sample, reference held in a register.
// MON_HYST_EN selects hysteresis around +/-HYST; otherwise a plain MSB sign change counts.
module fir_mon_zc_detector #(
    parameter int DATA_W = 32,
    parameter int HYST   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] sample,
    input  logic                     valid,
    input  logic                     first,
    output logic                     crossing
);

    logic ref_neg;
    logic ref_neg_next;

`ifdef MON_HYST_EN
    localparam logic signed [DATA_W-1:0] POS_TH = DATA_W'(HYST);
    localparam logic signed [DATA_W-1:0] NEG_TH = DATA_W'(-HYST);

    always_comb begin
        crossing     = 1'b0;
        ref_neg_next = ref_neg;
        if (valid) begin
            if (first) begin
                ref_neg_next = sample[DATA_W-1];
            end else if (ref_neg && (sample > POS_TH)) begin
                crossing     = 1'b1;
                ref_neg_next = 1'b0;
            end else if (!ref_neg && (sample < NEG_TH)) begin
                crossing     = 1'b1;
                ref_neg_next = 1'b1;
            end
        end
    end
`else
    logic [DATA_W-1:0] unused_hyst;
    assign unused_hyst = DATA_W'(HYST);

    always_comb begin
        crossing     = 1'b0;
        ref_neg_next = ref_neg;
        if (valid) begin
            ref_neg_next = sample[DATA_W-1];
            if (!first) begin
                crossing = (sample[DATA_W-1] != ref_neg);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_neg <= 1'b0;
        end else begin
            ref_neg <= ref_neg_next;
        end
    end

endmodule

// File: rtl/fir_output_monitor.sv
// Measures max/min/peak-to-peak/zero crossings over a window after a settle period; results one cycle after the last sample.
// Results held in REPORT until res_valid && res_ready; samples arriving then are dropped and flagged.
module fir_output_monitor
    import fir_mon_pkg::*;
#(
    parameter int DATA_W         = FIR_MON_DATA_W,
    parameter int SETTLE_SAMPLES = FIR_MON_SETTLE_SAMPLES,
    parameter int WINDOW         = FIR_MON_WINDOW,
    parameter int ZC_W           = FIR_MON_ZC_W,
    parameter int HYST           = FIR_MON_HYST
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_data,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [DATA_W-1:0] res_max,
    output logic signed [DATA_W-1:0] res_min,
    output logic [DATA_W:0]          res_p2p,
    output logic [ZC_W-1:0]          res_zc,
    output logic                     res_dropped
);

    localparam int SETTLE_W = cnt_w(SETTLE_SAMPLES);
    localparam int WIN_W    = cnt_w(WINDOW);
    localparam fir_mon_state_t RUN_STATE = (SETTLE_SAMPLES == 0) ? MEASURE : SETTLE;

    fir_mon_state_t state, state_next;

    logic [SETTLE_W-1:0]      settle_cnt;
    logic [WIN_W-1:0]         win_cnt;
    logic signed [DATA_W-1:0] cur_max, cur_min, max_next, min_next;
    logic [ZC_W-1:0]          zc_cnt, zc_next;
    logic handshake, accept_start, meas_vld, first, crossing;
    logic settle_last, win_last;

    assign handshake    = (state == REPORT) && res_ready;
    assign accept_start = start && ((state == IDLE) || handshake);
    assign meas_vld     = (state == MEASURE) && sample_valid;
    assign first        = (win_cnt == '0);
    assign settle_last  = (settle_cnt == SETTLE_W'(SETTLE_SAMPLES - 1));
    assign win_last     = (win_cnt == WIN_W'(WINDOW - 1));
    assign busy         = (state != IDLE);
    assign res_valid    = (state == REPORT);

    fir_mon_zc_detector #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_zc (
        .clk      (clk),
        .reset    (reset),
        .sample   (sample_data),
        .valid    (meas_vld),
        .first    (first),
        .crossing (crossing)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_start) state_next = RUN_STATE;
            SETTLE:  if (sample_valid && settle_last) state_next = MEASURE;
            MEASURE: if (meas_vld && win_last) state_next = REPORT;
            REPORT:  if (handshake) state_next = accept_start ? RUN_STATE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        max_next = cur_max;
        min_next = cur_min;
        zc_next  = zc_cnt;
        if (meas_vld) begin
            if (first) begin
                max_next = sample_data;
                min_next = sample_data;
                zc_next  = '0;
            end else begin
                if (sample_data > cur_max) max_next = sample_data;
                if (sample_data < cur_min) min_next = sample_data;
                // Saturate rather than wrap so a noisy window never reads as quiet.
                if (crossing && (zc_cnt != '1)) zc_next = zc_cnt + ZC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            win_cnt     <= '0;
            cur_max     <= '0;
            cur_min     <= '0;
            zc_cnt      <= '0;
            res_max     <= '0;
            res_min     <= '0;
            res_p2p     <= '0;
            res_zc      <= '0;
            res_dropped <= 1'b0;
        end else begin
            state   <= state_next;
            cur_max <= max_next;
            cur_min <= min_next;
            zc_cnt  <= zc_next;
            if (accept_start) begin
                settle_cnt  <= '0;
                win_cnt     <= '0;
                res_dropped <= 1'b0;
            end else begin
                if ((state == SETTLE) && sample_valid)
                    settle_cnt <= settle_last ? '0 : settle_cnt + SETTLE_W'(1);
                if (meas_vld)
                    win_cnt <= win_last ? '0 : win_cnt + WIN_W'(1);
                if ((state == REPORT) && sample_valid)
                    res_dropped <= 1'b1;
            end
            if (meas_vld && win_last) begin
                res_max <= max_next;
                res_min <= min_next;
                // Sign-extend by one bit so max - min cannot overflow.
                res_p2p <= {max_next[DATA_W-1], max_next} - {min_next[DATA_W-1], min_next};
                res_zc  <= zc_next;
            end
        end
    end

endmodule

// File: tb/tb_fir_output_monitor.sv
// Scoreboard bench for fir_output_monitor: expected results queued at stimulus time, compared in REPORT.
module tb_fir_output_monitor;

    localparam int DW  = 32;
    localparam int SS  = 4;
    localparam int WIN = 8;
    localparam int ZW  = 16;
    localparam int HY  = 64;

    logic clk = 1'b0;
    logic reset, start, sample_valid, res_ready;
    logic signed [DW-1:0] sample_data;
    logic busy, res_valid, res_dropped;
    logic signed [DW-1:0] res_max, res_min;
    logic [DW:0]          res_p2p;
    logic [ZW-1:0]        res_zc;

    typedef struct {
        logic signed [DW-1:0] mx;
        logic signed [DW-1:0] mn;
        logic [DW:0]          p2p;
        logic [ZW-1:0]        zc;
    } exp_t;

    exp_t sb[$];
    logic signed [DW-1:0] stim [WIN];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fir_output_monitor #(
        .DATA_W         (DW),
        .SETTLE_SAMPLES (SS),
        .WINDOW         (WIN),
        .ZC_W           (ZW),
        .HYST           (HY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .busy         (busy),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_max      (res_max),
        .res_min      (res_min),
        .res_p2p      (res_p2p),
        .res_zc       (res_zc),
        .res_dropped  (res_dropped)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t   e;
        logic   rn;
        longint d;
        e.mx = stim[0];
        e.mn = stim[0];
        e.zc = '0;
        rn   = stim[0][DW-1];
        for (int i = 1; i < WIN; i++) begin
            if (stim[i] > e.mx) e.mx = stim[i];
            if (stim[i] < e.mn) e.mn = stim[i];
`ifdef MON_HYST_EN
            if (rn && (stim[i] > HY)) begin
                e.zc++;
                rn = 1'b0;
            end else if (!rn && (stim[i] < -HY)) begin
                e.zc++;
                rn = 1'b1;
            end
`else
            if (stim[i][DW-1] != rn) e.zc++;
            rn = stim[i][DW-1];
`endif
        end
        d     = longint'(e.mx) - longint'(e.mn);
        e.p2p = d[DW:0];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
    endtask

    // A gap cycle also pulses start, which must be ignored mid-run.
    task automatic feed(input logic signed [DW-1:0] d, input bit gap);
        if (gap) begin
            sample_valid = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic feed_settle(input bit gap);
        for (int i = 0; i < SS; i++) feed((i % 2 == 1) ? -32'sd5000 : 32'sd5000, gap);
    endtask

    task automatic feed_run(input bit gap);
        feed_settle(gap);
        sb.push_back(model());
        for (int i = 0; i < WIN; i++) feed(stim[i], gap);
        check_eq("res_valid_rise", res_valid, 1);
        check_eq("busy_report", busy, 1);
    endtask

    task automatic collect(input int hold, input bit drop, input bit restart);
        exp_t e;
        int   t;
        t = 0;
        while (!res_valid && t < 20) begin
            tick();
            t++;
        end
        if (!res_valid || sb.size() == 0) begin
            check_eq("res_valid_timeout", {63'd0, res_valid}, 64'd1 + 64'(sb.size() == 0));
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        for (int c = 0; c < hold; c++) begin
            sample_valid = drop && (c % 2 == 0);
            sample_data  = 32'sd12345;
            check_eq("hold_valid", res_valid, 1);
            check_eq("hold_max", res_max, e.mx);
            check_eq("hold_min", res_min, e.mn);
            check_eq("hold_p2p", res_p2p, e.p2p);
            check_eq("hold_zc", res_zc, e.zc);
            tick();
        end
        sample_valid = 1'b0;
        check_eq("res_max", res_max, e.mx);
        check_eq("res_min", res_min, e.mn);
        check_eq("res_p2p", res_p2p, e.p2p);
        check_eq("res_zc", res_zc, e.zc);
        check_eq("res_dropped", res_dropped, drop);
        res_ready = 1'b1;
        start     = restart;
        tick();
        res_ready = 1'b0;
        start     = 1'b0;
        check_eq("valid_fall", res_valid, 0);
        check_eq("busy_after_hs", busy, restart);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_valid"}, res_valid, 0);
        check_eq({tag, "_max"}, res_max, 0);
        check_eq({tag, "_min"}, res_min, 0);
        check_eq({tag, "_p2p"}, res_p2p, 0);
        check_eq({tag, "_zc"}, res_zc, 0);
        check_eq({tag, "_dropped"}, res_dropped, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sample_valid = 1'b0;
        sample_data = '0;
        res_ready = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Samples in IDLE must not start anything.
        sample_valid = 1'b1;
        sample_data  = 32'sd123;
        tick();
        tick();
        sample_valid = 1'b0;
        check_eq("idle_ignores", busy, 0);

        for (int i = 0; i < WIN; i++) stim[i] = (i % 2 == 1) ? -32'sd100 : 32'sd100;
        start_run();
        feed_run(1'b0);
        collect(3, 1'b0, 1'b0);

        for (int i = 0; i < WIN; i++) stim[i] = (i % 2 == 1) ? -32'sd50 : 32'sd50;
        start_run();
        feed_run(1'b0);
        collect(0, 1'b0, 1'b0);

        stim = '{32'sd300, -32'sd20, 32'sd7, 32'sd0, -32'sd1, 32'sd9000, -32'sd9000, 32'sd1};
        start_run();
        feed_run(1'b1);
        collect(10, 1'b1, 1'b0);

        stim = '{32'sd0, 32'sh7FFF_FFFF, -32'sd5, 32'sh8000_0000, 32'sd1, -32'sd1, 32'sd100, 32'sd0};
        start_run();
        feed_run(1'b0);
        collect(2, 1'b0, 1'b1);

        // Run started on the handshake cycle above.
        stim = '{32'sd0, 32'sd3, -32'sd2, 32'sd0, 32'sd0, -32'sd7, 32'sd4, 32'sd1};
        feed_run(1'b0);
        collect(1, 1'b0, 1'b0);

        start_run();
        feed_settle(1'b0);
        for (int i = 0; i < 3; i++) feed(32'sd777, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("abort");
        sample_valid = 1'b1;
        tick();
        tick();
        sample_valid = 1'b0;
        check_eq("abort_idle", busy, 0);

        for (int i = 0; i < WIN; i++) stim[i] = $urandom;
        start_run();
        feed_run(1'b0);
        collect(0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
